// File: rtl/button_input.sv
// button_input: synchronises, debounces and edge-detects active-low push buttons,
// producing press/release pulses and Tetris-style auto-repeat pulses per button.
module button_input #(
    parameter int N_BTN               = 2,
    parameter int DEBOUNCE_CYCLES     = 270000,
    parameter int REPEAT_DELAY_CYCLES = 8100000,
    parameter int REPEAT_RATE_CYCLES  = 2700000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE_CYCLES - 1);
    genvar i;
    for (i = 0; i < N_BTN; i++) begin : g_ch
        logic          s1, s2, level, press, rel, rep, flip, tmr_hit;
        logic [DW-1:0] cnt;
        logic [TW-1:0] tmr;
        logic [1:0]    st;
        always_comb begin
            flip    = (s2 != level) && (cnt == DB_LAST);
            tmr_hit = (st == DELAY) ? (tmr == DLY_LAST) : (st == REPEAT) && (tmr == RATE_LAST);
        end
        // a level flip overrides the timer, so a release never emits a repeat
        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
                rep   <= 1'b0;
                tmr   <= '0;
                st    <= IDLE;
            end else begin
                s1    <= ~btn_n[i];
                s2    <= s1;
                cnt   <= (s2 == level || flip) ? '0 : cnt + 1'b1;
                level <= level ^ flip;
                press <= flip && !level;
                rel   <= flip && level;
                rep   <= flip ? !level : tmr_hit;
                st    <= flip ? (level ? IDLE : DELAY) : (tmr_hit ? REPEAT : st);
                tmr   <= (flip || tmr_hit || st == IDLE) ? '0 : tmr + 1'b1;
            end
        end
        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = rel;
        assign btn_repeat[i]  = rep;
    end
endmodule

// File: tb/tb_button_input.sv
// tb_button_input: scoreboard bench for button_input; expected pulses are queued
// with their absolute cycle when stimulus is driven and compared every cycle.
module tb_button_input;
    localparam int DB      = 4;
    localparam int DLY     = 10;
    localparam int RATE    = 3;
    localparam int LAT     = 2 + DB;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [7:0] obs;

    button_input #(
        .N_BTN(2),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES(RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n(btn_n),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {btn_level, btn_press, btn_release, btn_repeat};

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;
    ev_t        sb[$];
    int         p0[2];
    logic [1:0] exp_lvl = 2'b00;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic push(input int c, input int ch, input int kind);
        ev_t ev;
        ev.cyc  = c;
        ev.ch   = ch;
        ev.kind = kind;
        sb.push_back(ev);
    endtask

    // press pulse and first repeat land LAT edges after the pin changes
    task automatic sched_press(input int ch);
        btn_n[ch] = 1'b0;
        p0[ch] = cyc + LAT;
        push(p0[ch], ch, K_PRESS);
        push(p0[ch], ch, K_REP);
    endtask

    task automatic push_repeats(input int ch, input int lo, input int hi);
        for (int t = p0[ch] + DLY; t < hi; t += RATE)
            if (t >= lo) push(t, ch, K_REP);
    endtask

    task automatic sched_release(input int ch);
        btn_n[ch] = 1'b1;
        push_repeats(ch, cyc + 1, cyc + LAT);
        push(cyc + LAT, ch, K_REL);
    endtask

    task automatic next_cycle(output logic [7:0] e);
        logic [1:0] p, r, rp;
        p  = 2'b00;
        r  = 2'b00;
        rp = 2'b00;
        @(posedge clk);
        #1;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                if (sb[k].kind == K_PRESS) p[sb[k].ch] = 1'b1;
                else if (sb[k].kind == K_REL) r[sb[k].ch] = 1'b1;
                else rp[sb[k].ch] = 1'b1;
                sb.delete(k);
            end
        end
        exp_lvl = (exp_lvl | p) & ~r;
        e = {exp_lvl, p, r, rp};
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int n = 0; n < 24; n++) begin
            btn_n = (n >= 3 && n < 11) ? 2'b00 : 2'b11;
            rst = (n < 14);
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] e;
        sched_press(0);
        while (cyc < p0[0] + 5) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [7:0] e;
        push_repeats(0, cyc + 1, p0[0] + 31);
        while (cyc < p0[0] + 30) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL auto_repeat cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_release();
        logic [7:0] e;
        int         t;
        sched_release(0);
        t = cyc + LAT + 6;
        while (cyc < t) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL release cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        sched_press(0);
        push_repeats(0, cyc + 1, p0[0] + 13);
        while (cyc < p0[0] + 12) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL repress cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        sched_release(0);
        t = cyc + LAT + 4;
        while (cyc < t) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL repress_release cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] e;
        for (int n = 0; n < 30; n++) begin
            btn_n[0] = (n < 20 && (n / 2) % 2 == 0) ? 1'b0 : 1'b1;
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] e;
        int         t;
        sched_press(0);
        push_repeats(0, cyc + 1, p0[0] + 14);
        while (cyc < p0[0] + 13) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold_before_rst cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        rst = 1'b1;
        exp_lvl = 2'b00;
        for (int n = 0; n < 3; n++) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_rst cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        rst = 1'b0;
        sched_press(0);
        while (cyc < p0[0] + 5) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_repress cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        sched_release(0);
        t = cyc + LAT + 4;
        while (cyc < t) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_release cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        int         t;
        sched_press(0);
        sched_press(1);
        push_repeats(0, cyc + 1, p0[0] + 15);
        push_repeats(1, cyc + 1, p0[1] + 15);
        while (cyc < p0[0] + 14) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL simul_press cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        sched_release(1);
        push_repeats(0, cyc + 1, p0[0] + 31);
        while (cyc < p0[0] + 30) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL simul_one_release cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        sched_release(0);
        t = cyc + LAT + 4;
        while (cyc < t) begin
            next_cycle(e);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL simul_release cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained got=%0d pending exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_auto_repeat();
        test_release();
        test_bounce();
        test_reset_mid_hold();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
